// File: rtl/tff_updown_counter_if.sv
// Control and status bundle for the T-flop up/down counter.
// The master drives the count controls; the slave (the counter) returns state and toggle info.
interface tff_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] t;
  logic             tc;

  modport master (
    output en, up, load, d,
    input  q, qbar, t, tc
  );

  modport slave (
    input  en, up, load, d,
    output q, qbar, t, tc
  );
endinterface

// File: rtl/tff_updown_counter.sv
// Mod-MODULUS up/down counter whose state bits are T flip-flops; the toggle vector is exported.
// Falling-edge clocked, synchronous active-high reset, priority reset > load > enable.
module tff_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  tff_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;
  logic [WIDTH-1:0] tgl_up;
  logic [WIDTH-1:0] tgl_dn;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] t_vec;
  logic             at_max;
  logic             at_min;
  logic             load_clamp;

  assign at_max     = (q_q == MaxVal);
  assign at_min     = (q_q == '0);
  assign load_clamp = ({1'b0, bus.d} >= ModExt);

  // Binary T-flop toggle terms: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    tgl_up   = '0;
    tgl_dn   = '0;
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask  = WIDTH'((1 << i) - 1);
      tgl_up[i] = &(q_q | ~low_mask);
      tgl_dn[i] = ~|(q_q & low_mask);
    end
  end

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (rst_i) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = load_clamp ? MaxVal : bus.d;
    end else if (bus.en) begin
      if (bus.up) begin
        if (at_max) begin
          tc_d = 1'b1;
          q_d  = (SATURATE != 0) ? q_q : '0;
        end else begin
          q_d = q_q ^ tgl_up;
        end
      end else begin
        if (at_min) begin
          tc_d = 1'b1;
          q_d  = (SATURATE != 0) ? q_q : MaxVal;
        end else begin
          q_d = q_q ^ tgl_dn;
        end
      end
    end
  end

  // Wrap, clamp and reset are folded into the toggle vector so every bit stays a pure T flop.
  assign t_vec = q_q ^ q_d;

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_q ^ t_vec;
      tc_q <= tc_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.t    = t_vec;
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed bench for tff_updown_counter: wrap-mode vector table plus a saturate-mode sequence.
module tb_tff_updown_counter;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] d;
    logic       chk_t;
    logic [3:0] t;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic [3:0] d = 4'h0;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  tff_updown_counter_if #(.WIDTH(4)) bus_wrap ();
  tff_updown_counter_if #(.WIDTH(4)) bus_sat ();

  assign bus_wrap.en   = en;
  assign bus_wrap.up   = up;
  assign bus_wrap.load = load;
  assign bus_wrap.d    = d;
  assign bus_sat.en    = en;
  assign bus_sat.up    = up;
  assign bus_sat.load  = load;
  assign bus_sat.d     = d;

  tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_wrap.slave)
  );

  tff_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_sat.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic e, input logic u,
                     input logic [3:0] dv, input logic ct, input logic [3:0] et,
                     input logic [3:0] eq, input logic etc);
    vecs.push_back('{rst: r, load: l, en: e, up: u, d: dv, chk_t: ct, t: et, q: eq, tc: etc});
  endtask

  // Inputs change just after the rising edge, well away from the falling active edge.
  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] dv);
    @(posedge clk);
    rst  = r;
    load = l;
    en   = e;
    up   = u;
    d    = dv;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic sat_step(input string nm, input logic r, input logic l, input logic e,
                          input logic u, input logic [3:0] dv, input logic [3:0] et,
                          input logic [3:0] eq, input logic etc);
    drive(r, l, e, u, dv);
    chk({nm, "_t"}, bus_sat.t, et);
    settle();
    chk({nm, "_q"}, bus_sat.q, eq);
    chk({nm, "_tc"}, bus_sat.tc, etc);
  endtask

  initial begin
    logic [3:0] exp_qbar;

    // rst load en up d  chk_t  t  q  tc
    add(1, 0, 0, 0, 4'd0, 0, 4'b0000, 4'd0, 0);
    // count up through the 9 -> 0 wrap
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd1, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0011, 4'd2, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd3, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0111, 4'd4, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd5, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0011, 4'd6, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd7, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b1111, 4'd8, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd9, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b1001, 4'd0, 1);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd1, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0011, 4'd2, 0);
    // count down through the 0 -> 9 wrap
    add(0, 0, 1, 0, 4'd0, 1, 4'b0011, 4'd1, 0);
    add(0, 0, 1, 0, 4'd0, 1, 4'b0001, 4'd0, 0);
    add(0, 0, 1, 0, 4'd0, 1, 4'b1001, 4'd9, 1);
    add(0, 0, 1, 0, 4'd0, 1, 4'b0001, 4'd8, 0);
    add(0, 0, 1, 0, 4'd0, 1, 4'b1111, 4'd7, 0);
    // load clamp, plain load, hold
    add(0, 1, 1, 1, 4'd13, 1, 4'b1110, 4'd9, 0);
    add(0, 1, 0, 0, 4'd5, 1, 4'b1100, 4'd5, 0);
    add(0, 0, 0, 1, 4'd0, 1, 4'b0000, 4'd5, 0);
    add(0, 0, 0, 0, 4'd0, 1, 4'b0000, 4'd5, 0);
    add(0, 0, 0, 1, 4'd0, 1, 4'b0000, 4'd5, 0);
    // load clears a pending TC, D = MODULUS clamps
    add(0, 1, 0, 0, 4'd9, 1, 4'b1100, 4'd9, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b1001, 4'd0, 1);
    add(0, 1, 1, 1, 4'd4, 1, 4'b0100, 4'd4, 0);
    add(0, 1, 0, 1, 4'd10, 1, 4'b1101, 4'd9, 0);
    // reset at the boundary suppresses the TC pulse; T equals Q during reset
    add(1, 0, 1, 1, 4'd0, 1, 4'b1001, 4'd0, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd1, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0011, 4'd2, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd3, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0111, 4'd4, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd5, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0011, 4'd6, 0);
    // reset beats load
    add(1, 1, 1, 1, 4'd3, 1, 4'b0110, 4'd0, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0001, 4'd1, 0);
    add(0, 0, 1, 1, 4'd0, 1, 4'b0011, 4'd2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].d);
      if (vecs[i].chk_t) chk($sformatf("v%0d_t", i), bus_wrap.t, vecs[i].t);
      settle();
      exp_qbar = ~vecs[i].q;
      chk($sformatf("v%0d_q", i), bus_wrap.q, vecs[i].q);
      chk($sformatf("v%0d_tc", i), bus_wrap.tc, vecs[i].tc);
      chk($sformatf("v%0d_qbar", i), bus_wrap.qbar, exp_qbar);
    end

    // saturate-mode instance: hold at the top with repeated TC, then leave downward
    sat_step("sat_ld9", 0, 1, 0, 0, 4'd9, 4'b1011, 4'd9, 0);
    sat_step("sat_up0", 0, 0, 1, 1, 4'd0, 4'b0000, 4'd9, 1);
    sat_step("sat_up1", 0, 0, 1, 1, 4'd0, 4'b0000, 4'd9, 1);
    sat_step("sat_up2", 0, 0, 1, 1, 4'd0, 4'b0000, 4'd9, 1);
    sat_step("sat_dn",  0, 0, 1, 0, 4'd0, 4'b0001, 4'd8, 0);
    // hold at the bottom, then leave upward
    sat_step("sat_ld0", 0, 1, 1, 0, 4'd0, 4'b1000, 4'd0, 0);
    sat_step("sat_lo0", 0, 0, 1, 0, 4'd0, 4'b0000, 4'd0, 1);
    sat_step("sat_lo1", 0, 0, 1, 0, 4'd0, 4'b0000, 4'd0, 1);
    sat_step("sat_upx", 0, 0, 1, 1, 4'd0, 4'b0001, 4'd1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tff_updown_counter.md
Name: tff_updown_counter

Overview:
- Synchronous mod-N up/down counter built on T flip-flop toggle equations. Each bit toggles when its toggle enable is high.
- It is the counting counterpart to the single toggle flop: the same cell family, usable in both directions, with parallel load and a terminal-count flag.
- It exposes the per-bit toggle vector, so downstream logic and the bench can check the toggle equations directly.
- It sits in the lab datapath as the standard sequence/timer element.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- SATURATE, 0. When 0, the counter wraps at the boundaries. When 1, it holds at the boundary.

Ports:
- CLK  input  1  Clock. All state updates happen on the falling edge.
- RST  input  1  Synchronous active-high reset, sampled on the falling edge of CLK.
- EN  input  1  Count enable.
- UP  input  1  Direction: 1 = increment, 0 = decrement.
- LOAD  input  1  Parallel load strobe.
- D  input  WIDTH  Parallel load value.
- Q  output  WIDTH  Registered count.
- Qbar  output  WIDTH  Bitwise ~Q, combinational.
- T  output  WIDTH  Toggle vector Q ^ Q_next, combinational: the bits that change on the next falling edge.
- TC  output  1  Registered terminal-count pulse.

Behaviour:
- One clock (CLK, falling edge). Reset is synchronous and active-high. No asynchronous paths.
- Priority per edge: RST > LOAD > EN. With none of them asserted, Q holds and T = 0.
- Reset values: Q = 0, TC = 0. Qbar therefore = all ones after reset.
- Q is undefined until the first RST edge. The bench must reset first.
- RST edge: Q ← 0, TC ← 0. Reset mid-count discards any pending boundary event. TC is 0 in the following cycle.
- LOAD edge:
  - Q ← D when D < MODULUS.
  - Q ← MODULUS-1 when D ≥ MODULUS (clamp).
  - TC ← 0. EN and UP are ignored on a load edge.
- EN edge, UP = 1:
  - Q < MODULUS-1: Q ← Q+1.
  - Q = MODULUS-1 with SATURATE = 0: Q ← 0.
  - Q = MODULUS-1 with SATURATE = 1: Q holds.
- EN edge, UP = 0:
  - Q > 0: Q ← Q-1.
  - Q = 0 with SATURATE = 0: Q ← MODULUS-1.
  - Q = 0 with SATURATE = 1: Q holds.
- Boundary event: an EN edge (RST = 0, LOAD = 0) where Q is at the boundary in the current direction, i.e. MODULUS-1 when counting up, 0 when counting down.
  - TC ← 1 on a boundary-event edge and stays high for exactly one cycle, until the next falling edge.
  - TC ← 0 on every other edge.
  - In saturate mode TC re-asserts on every enabled edge spent at the boundary.
- Direction change (UP flipping between edges) takes effect on the next edge. There is no extra latency.
- Latency: Q and TC change on the same falling edge as the sampled controls. T and Qbar follow Q combinationally.
- T vector:
  - Equals Q ^ Q_next for the currently presented RST, LOAD, EN, UP and D.
  - During RST, T = Q.
  - For binary up-counting away from the wrap point, T[i] = EN & (Q[i-1:0] all ones).
  - For down-counting away from the wrap point, T[i] = EN & (Q[i-1:0] all zeros).
- Arithmetic is unsigned, WIDTH bits. Q never leaves 0..MODULUS-1 after reset.

Test Plan:
- Setup: WIDTH = 4, MODULUS = 10, SATURATE = 0. Hold RST for 1 falling edge → Q = 0, Qbar = 4'hF, TC = 0.
- EN = 1, UP = 1 for 12 edges → Q sequence 1..9, 0, 1, 2. TC = 1 only in the cycle after the 9→0 edge. T = 4'b1001 while Q = 9.
- EN = 1, UP = 0 from Q = 0 → Q = 9, TC pulses once. Before that edge T = 4'b1001. Two more edges → Q = 8, 7, TC = 0.
- LOAD = 1 with D = 13, EN = 1, UP = 1 → Q = 9 (clamp), TC = 0. LOAD = 1 with D = 5 → Q = 5. EN = 0 for 3 edges → Q holds at 5, T = 0.
- SATURATE = 1, Q = 9, EN = 1, UP = 1 for 3 edges → Q stays 9, TC = 1 in each of the 3 cycles. Then UP = 0 → Q = 8, TC = 0.
- Count to Q = 6, then assert RST together with LOAD = 1, D = 3 → Q = 0, TC = 0 (RST wins). Release RST and count up 2 edges → Q = 1, 2.
